// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } pc_state_e;

  localparam int STEP_16 = 2;
  localparam int STEP_32 = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch handshake between the PC generator (master) and the I-fetch stage (slave).
interface pc_gen_if #(
  parameter int XLEN    = 32,
  parameter int EPOCH_W = 2
) ();

  logic               pc_valid;
  logic               pc_ready;
  logic [XLEN-1:0]    pc_out;
  logic [EPOCH_W-1:0] pc_epoch;
  logic               step_c;

  modport master (
    output pc_valid,
    output pc_out,
    output pc_epoch,
    input  pc_ready,
    input  step_c
  );

  modport slave (
    input  pc_valid,
    input  pc_out,
    input  pc_epoch,
    output pc_ready,
    output step_c
  );

endinterface

// File: rtl/pc_step_add.sv
// Sequential-fetch adder: advances the PC by one 16-bit or one 32-bit instruction.
module pc_step_add
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            half_step,
  output logic [XLEN-1:0] pc_inc
);

  // Wraps modulo 2^XLEN; no carry out is kept.
  assign pc_inc = pc + (half_step ? XLEN'(STEP_16) : XLEN'(STEP_32));

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: valid/ready PC source with trap/branch redirects,
// epoch tagging, WFI halt and misaligned-branch fault.
module pc_gen
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RST_ADDR = '0,
  parameter bit              C_EXT    = 1'b1,
  parameter int              EPOCH_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_gen_if.master        fetch,
  input  logic            br_vld,
  input  logic [XLEN-1:0] br_tgt,
  input  logic            trap_vld,
  input  logic [XLEN-1:0] trap_tgt,
  input  logic            wfi_req,
  input  logic            wake,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  localparam logic [XLEN-1:0] ALIGN_MASK = C_EXT ? XLEN'(1) : XLEN'(3);

  pc_state_e          state_reg, state_next;
  logic [XLEN-1:0]    pc_reg, pc_next;
  logic [EPOCH_W-1:0] epoch_reg, epoch_next;
  logic               valid_reg, valid_next;
  logic               err_reg, err_next;
  logic [XLEN-1:0]    addr_reg, addr_next;

  logic               fire;
  logic               half_step;
  logic               br_misaligned;
  logic [XLEN-1:0]    pc_inc;
  logic [XLEN-1:0]    trap_aligned;
  logic [EPOCH_W-1:0] epoch_inc;

  assign fire          = valid_reg & fetch.pc_ready;
  assign half_step     = C_EXT & fetch.step_c;
  assign br_misaligned = |(br_tgt & ALIGN_MASK);
  // Trap targets are silently forced onto the legal alignment grid.
  assign trap_aligned  = trap_tgt & ~ALIGN_MASK;
  assign epoch_inc     = epoch_reg + EPOCH_W'(1);

  pc_step_add #(.XLEN(XLEN)) u_step_add (
    .pc        (pc_reg),
    .half_step (half_step),
    .pc_inc    (pc_inc)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    epoch_next = epoch_reg;
    err_next   = 1'b0;
    addr_next  = addr_reg;

    case (state_reg)
      BOOT: state_next = RUN;

      RUN: begin
        if (trap_vld) begin
          pc_next    = trap_aligned;
          epoch_next = epoch_inc;
        end else if (br_vld) begin
          // The epoch still bumps on a faulting branch so in-flight fetches get squashed.
          epoch_next = epoch_inc;
          if (br_misaligned) begin
            err_next   = 1'b1;
            addr_next  = br_tgt;
            state_next = FAULT;
          end else begin
            pc_next = br_tgt;
          end
        end else begin
          if (fire)    pc_next    = pc_inc;
          if (wfi_req) state_next = HALT;
        end
      end

      HALT: begin
        if (trap_vld) begin
          pc_next    = trap_aligned;
          epoch_next = epoch_inc;
          state_next = RUN;
        end else if (wake) begin
          state_next = RUN;
        end
      end

      FAULT: begin
        if (trap_vld) begin
          pc_next    = trap_aligned;
          epoch_next = epoch_inc;
          state_next = RUN;
        end
      end

      default: state_next = BOOT;
    endcase

    valid_next = (state_next == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RST_ADDR;
      epoch_reg <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      epoch_reg <= epoch_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      addr_reg  <= addr_next;
    end
  end

  assign fetch.pc_valid = valid_reg;
  assign fetch.pc_out   = pc_reg;
  assign fetch.pc_epoch = epoch_reg;
  assign misalign_err   = err_reg;
  assign misalign_addr  = addr_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a C_EXT=1 instance (RST_ADDR=0x100) and a C_EXT=0 instance.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // C_EXT=1 instance
  pc_gen_if #(.XLEN(32), .EPOCH_W(2)) bus1 ();
  logic        br_vld = 0, trap_vld = 0, wfi_req = 0, wake = 0;
  logic [31:0] br_tgt = 0, trap_tgt = 0;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  pc_gen #(.XLEN(32), .RST_ADDR(32'h100), .C_EXT(1'b1), .EPOCH_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch         (bus1.master),
    .br_vld        (br_vld),
    .br_tgt        (br_tgt),
    .trap_vld      (trap_vld),
    .trap_tgt      (trap_tgt),
    .wfi_req       (wfi_req),
    .wake          (wake),
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr)
  );

  // C_EXT=0 instance
  pc_gen_if #(.XLEN(32), .EPOCH_W(2)) bus0 ();
  logic        br0_vld = 0;
  logic [31:0] br0_tgt = 0;
  logic        misalign0_err;
  logic [31:0] misalign0_addr;

  pc_gen #(.XLEN(32), .RST_ADDR(32'h0), .C_EXT(1'b0), .EPOCH_W(2)) dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch         (bus0.master),
    .br_vld        (br0_vld),
    .br_tgt        (br0_tgt),
    .trap_vld      (1'b0),
    .trap_tgt      (32'h0),
    .wfi_req       (1'b0),
    .wake          (1'b0),
    .misalign_err  (misalign0_err),
    .misalign_addr (misalign0_addr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pc(input string tag, input logic [31:0] pc, input logic [1:0] ep,
                          input logic vld);
    check_val({tag, ".pc"},    bus1.pc_out,          pc);
    check_val({tag, ".epoch"}, 32'(bus1.pc_epoch),   32'(ep));
    check_val({tag, ".valid"}, 32'(bus1.pc_valid),   32'(vld));
  endtask

  initial begin
    bus1.pc_ready = 0; bus1.step_c = 0;
    bus0.pc_ready = 0; bus0.step_c = 0;
    tick(); tick();

    // Reset state
    check_pc("rst", 32'h100, 2'd0, 1'b0);
    check_val("rst.err",  32'(misalign_err), 32'h0);
    check_val("rst.addr", misalign_addr,     32'h0);

    // 1: boot, then four 32-bit fires
    rst_n = 1;
    check_val("boot.valid", 32'(bus1.pc_valid), 32'h0);
    tick();
    check_pc("boot", 32'h100, 2'd0, 1'b1);
    bus1.pc_ready = 1;
    tick(); check_pc("inc1", 32'h104, 2'd0, 1'b1);
    tick(); check_pc("inc2", 32'h108, 2'd0, 1'b1);
    tick(); check_pc("inc3", 32'h10C, 2'd0, 1'b1);
    tick(); check_pc("inc4", 32'h110, 2'd0, 1'b1);
    bus1.pc_ready = 0;

    // 2: redirect to 0x200, mixed 16/32-bit steps, then stall
    trap_vld = 1; trap_tgt = 32'h200;
    tick(); trap_vld = 0;
    check_pc("trap200", 32'h200, 2'd1, 1'b1);
    bus1.pc_ready = 1; bus1.step_c = 1;
    tick(); check_pc("c1", 32'h202, 2'd1, 1'b1);
    tick(); check_pc("c2", 32'h204, 2'd1, 1'b1);
    bus1.step_c = 0;
    tick(); check_pc("c3", 32'h208, 2'd1, 1'b1);
    bus1.pc_ready = 0; bus1.step_c = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_pc($sformatf("stall%0d", i), 32'h208, 2'd1, 1'b1);
    end
    bus1.step_c = 0;

    // 3: trap and branch together -> trap wins, epoch +1 once
    br_vld = 1; br_tgt = 32'h400; trap_vld = 1; trap_tgt = 32'h800;
    tick(); br_vld = 0; trap_vld = 0;
    check_pc("both", 32'h800, 2'd2, 1'b1);
    // Misaligned trap target is aligned, no fault
    trap_vld = 1; trap_tgt = 32'h803;
    tick(); trap_vld = 0;
    check_pc("trap_al", 32'h802, 2'd3, 1'b1);
    check_val("trap_al.err", 32'(misalign_err), 32'h0);

    // 4: misaligned branch -> FAULT, epoch wraps 3->0
    br_vld = 1; br_tgt = 32'h301;
    tick(); br_vld = 0;
    check_pc("mis", 32'h802, 2'd0, 1'b0);
    check_val("mis.err",  32'(misalign_err), 32'h1);
    check_val("mis.addr", misalign_addr,     32'h301);
    br_vld = 1; br_tgt = 32'h500; wake = 1;
    tick(); br_vld = 0; wake = 0;
    check_val("mis.pulse", 32'(misalign_err), 32'h0);
    check_pc("fault_ign", 32'h802, 2'd0, 1'b0);
    trap_vld = 1; trap_tgt = 32'h1000;
    tick(); trap_vld = 0;
    check_pc("fault_exit", 32'h1000, 2'd1, 1'b1);

    // 5: WFI halt for 5 cycles, then wake
    wfi_req = 1;
    tick(); wfi_req = 0;
    for (int i = 0; i < 5; i++) begin
      check_pc($sformatf("halt%0d", i), 32'h1000, 2'd1, 1'b0);
      tick();
    end
    wake = 1;
    tick(); wake = 0;
    check_pc("wake", 32'h1000, 2'd1, 1'b1);

    // Wrap at top of address space
    trap_vld = 1; trap_tgt = 32'hFFFF_FFFC;
    tick(); trap_vld = 0;
    check_pc("top", 32'hFFFF_FFFC, 2'd2, 1'b1);
    bus1.pc_ready = 1;
    tick(); bus1.pc_ready = 0;
    check_pc("wrap", 32'h0, 2'd2, 1'b1);

    // Redirect in same cycle as wfi_req drops the wfi
    br_vld = 1; br_tgt = 32'h40; wfi_req = 1;
    tick(); br_vld = 0; wfi_req = 0;
    check_pc("br_wfi", 32'h40, 2'd3, 1'b1);
    tick();
    check_val("br_wfi.stay", 32'(bus1.pc_valid), 32'h1);

    // Async reset mid-stall
    #3 rst_n = 0;
    #1 check_pc("async_rst", 32'h100, 2'd0, 1'b0);
    tick(); rst_n = 1;

    // C_EXT=0: step_c ignored, 2-byte target faults
    tick();
    check_val("x0.boot.pc", bus0.pc_out, 32'h0);
    bus0.pc_ready = 1; bus0.step_c = 1;
    tick(); check_val("x0.inc1", bus0.pc_out, 32'h4);
    tick(); check_val("x0.inc2", bus0.pc_out, 32'h8);
    bus0.pc_ready = 0; bus0.step_c = 0;
    br0_vld = 1; br0_tgt = 32'h102;
    tick(); br0_vld = 0;
    check_val("x0.mis.err",   32'(misalign0_err),  32'h1);
    check_val("x0.mis.addr",  misalign0_addr,      32'h102);
    check_val("x0.mis.pc",    bus0.pc_out,         32'h8);
    check_val("x0.mis.valid", 32'(bus0.pc_valid),  32'h0);
    check_val("x0.mis.epoch", 32'(bus0.pc_epoch),  32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
